func_test_monitor: RTL and testbench

//   Simulation-side checker sitting directly downstream of top: samples the CPU's
//   pc/instr and data-memory write bus (memwrite, dataadr, writedata) every cycle.

---
 rtl/func_test_monitor_if.sv | 41 ++++
 rtl/func_test_monitor.sv | 198 +++++++++++++++++++
 tb/tb_func_test_monitor.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/func_test_monitor_if.sv
// ---------------------------------------------------------------------------
// func_test_monitor_if
//   Groups the signals between the CPU under test (plus the bench) and the
//   function-test monitor.
//   CPU-side sample bus : pc, instr, memwrite, dataadr, writedata
//   Trace FIFO drain    : trace_valid, trace_ready, trace_addr, trace_data,
//                         trace_ovf
//   Verdict/statistics  : status, done, write_count, cycle_count
//   modport master : the side that drives the CPU bus and drains the trace
//   modport slave  : the monitor itself
// ---------------------------------------------------------------------------
interface func_test_monitor_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;

  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_ovf;

  logic [1:0]  status;
  logic        done;
  logic [15:0] write_count;
  logic [31:0] cycle_count;

  modport master (
    output pc, instr, memwrite, dataadr, writedata, trace_ready,
    input  trace_valid, trace_addr, trace_data, trace_ovf,
    input  status, done, write_count, cycle_count
  );

  modport slave (
    input  pc, instr, memwrite, dataadr, writedata, trace_ready,
    output trace_valid, trace_addr, trace_data, trace_ovf,
    output status, done, write_count, cycle_count
  );
endinterface

// File: rtl/func_test_monitor.sv
// ---------------------------------------------------------------------------
// func_test_monitor
//   Watches the CPU fetch pc and data-memory write bus every cycle and decides
//   whether the function test passed (magic value stored to the pass address),
//   failed (any other value stored there) or hung (pc stuck, or cycle budget
//   exhausted). Every memory write seen while running is also pushed into a
//   small show-ahead trace FIFO that the bench drains at its own pace.
//
// Ports
//   clk  in  clock, everything on the rising edge
//   rst  in  synchronous active-high reset, clears all state
//   bus  slave modport of func_test_monitor_if:
//     pc/instr/memwrite/dataadr/writedata  in   sampled CPU bus
//     trace_valid/addr/data                out  FIFO head (0 when empty)
//     trace_ready                          in   pop head when valid & ready
//     trace_ovf                            out  sticky, a write was dropped
//     status                               out  00 RUN 01 PASS 10 FAIL 11 HANG
//     done                                 out  status != RUN
//     write_count                          out  writes seen in RUN (saturating)
//     cycle_count                          out  cycles spent in RUN
// ---------------------------------------------------------------------------
module func_test_monitor #(
  parameter logic [31:0] PASS_ADDR   = 32'h0000_0054,
  parameter logic [31:0] PASS_DATA   = 32'h0000_0007,
  parameter int          HANG_CYCLES = 64,
  parameter int          MAX_CYCLES  = 100000,
  parameter int          TRACE_DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  func_test_monitor_if.slave bus
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(HANG_CYCLES) + 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_PASS = 2'b01,
    ST_FAIL = 2'b10,
    ST_HANG = 2'b11
  } state_t;

  state_t         state_reg;
  state_t         state_next;
  logic           in_run;

  logic [31:0]    last_pc_reg;
  logic [SW-1:0]  stall_cnt_reg;
  logic [15:0]    write_count_reg;
  logic [31:0]    cycle_count_reg;

  logic [63:0]    trace_mem [TRACE_DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  fifo_count_reg;
  logic           trace_ovf_reg;

  logic           pc_equal;
  logic           pass_hit;
  logic           fail_hit;
  logic           stall_hang;
  logic           budget_hang;
  logic           push_req;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [63:0]    head;

  // instr is sampled by the bench environment only; reduce it so the port is
  // consumed without affecting any behaviour.
  logic           unused_instr;
  assign unused_instr = ^bus.instr;

  // -------------------------------------------------------------------------
  // Verdict conditions
  // -------------------------------------------------------------------------
  assign pc_equal    = (bus.pc == last_pc_reg);
  assign pass_hit    = bus.memwrite && (bus.dataadr == PASS_ADDR) &&
                       (bus.writedata == PASS_DATA);
  assign fail_hit    = bus.memwrite && (bus.dataadr == PASS_ADDR) &&
                       (bus.writedata != PASS_DATA);
  // stall_cnt counts previous equal samples, so this fires on the
  // HANG_CYCLES-th consecutive equal sample.
  assign stall_hang  = pc_equal && (stall_cnt_reg == SW'(HANG_CYCLES - 1));
  assign budget_hang = (cycle_count_reg == 32'(MAX_CYCLES - 1));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state. PASS/FAIL take precedence over either hang source.
  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_RUN) begin
      if (pass_hit) begin
        state_next = ST_PASS;
      end else if (fail_hit) begin
        state_next = ST_FAIL;
      end else if (stall_hang || budget_hang) begin
        state_next = ST_HANG;
      end
    end
  end

  // FSM: outputs
  always_comb begin
    in_run     = (state_reg == ST_RUN);
    bus.status = state_reg;
    bus.done   = (state_reg != ST_RUN);
  end

  // -------------------------------------------------------------------------
  // Stall tracking and statistics
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc_reg     <= 32'h0;
      stall_cnt_reg   <= '0;
      write_count_reg <= 16'h0;
      cycle_count_reg <= 32'h0;
    end else begin
      last_pc_reg <= bus.pc;
      if (in_run) begin
        cycle_count_reg <= cycle_count_reg + 32'd1;
        if (bus.memwrite && (write_count_reg != 16'hFFFF)) begin
          write_count_reg <= write_count_reg + 16'd1;
        end
        // Saturate at the threshold so a long stall cannot wrap around.
        if (!pc_equal) begin
          stall_cnt_reg <= '0;
        end else if (stall_cnt_reg != SW'(HANG_CYCLES - 1)) begin
          stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign bus.write_count = write_count_reg;
  assign bus.cycle_count = cycle_count_reg;

  // -------------------------------------------------------------------------
  // Trace FIFO (show-ahead)
  // -------------------------------------------------------------------------
  assign fifo_full  = (fifo_count_reg == CW'(TRACE_DEPTH));
  assign fifo_empty = (fifo_count_reg == '0);
  assign pop        = !fifo_empty && bus.trace_ready;
  assign push_req   = in_run && bus.memwrite;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push       = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      trace_mem[wr_ptr_reg] <= {bus.dataadr, bus.writedata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      trace_ovf_reg  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
      if (push_req && !push) begin
        trace_ovf_reg <= 1'b1;
      end
    end
  end

  // Head is forced to zero while empty so stale RAM contents never show.
  assign head            = trace_mem[rd_ptr_reg];
  assign bus.trace_valid = !fifo_empty;
  assign bus.trace_addr  = fifo_empty ? 32'h0 : head[63:32];
  assign bus.trace_data  = fifo_empty ? 32'h0 : head[31:0];
  assign bus.trace_ovf   = trace_ovf_reg;

endmodule

// File: tb/tb_func_test_monitor.sv
module tb_func_test_monitor;

  localparam logic [31:0] PASS_ADDR   = 32'h0000_0054;
  localparam logic [31:0] PASS_DATA   = 32'h0000_0007;
  localparam int          HANG_CYCLES = 64;
  localparam int          MAX_CYCLES  = 300;
  localparam int          DEPTH       = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  func_test_monitor_if bus ();

  func_test_monitor #(
    .PASS_ADDR  (PASS_ADDR),
    .PASS_DATA  (PASS_DATA),
    .HANG_CYCLES(HANG_CYCLES),
    .MAX_CYCLES (MAX_CYCLES),
    .TRACE_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural reference: verdict, counters and a queue of trace entries.
  int          m_status;
  int          m_wc;
  int          m_cc;
  bit          m_ovf;
  logic [31:0] m_last_pc;
  int          m_eq_run;
  logic [63:0] m_q[$];

  task automatic model_reset();
    m_status  = 0;
    m_wc      = 0;
    m_cc      = 0;
    m_ovf     = 0;
    m_last_pc = 32'h0;
    m_eq_run  = 0;
    m_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    bit pop;
    int n;
    pop = (m_q.size() > 0) && bus.trace_ready;
    if (pop) void'(m_q.pop_front());
    if (m_status == 0) begin
      n = (bus.pc == m_last_pc) ? m_eq_run + 1 : 0;
      if (bus.memwrite) begin
        if (bus.dataadr == PASS_ADDR) m_status = (bus.writedata == PASS_DATA) ? 1 : 2;
        if (m_wc < 65535) m_wc++;
        if (m_q.size() < DEPTH) m_q.push_back({bus.dataadr, bus.writedata});
        else m_ovf = 1;
      end
      if (m_status == 0 && (n >= HANG_CYCLES || m_cc == MAX_CYCLES - 1)) m_status = 3;
      m_cc++;
      m_eq_run = n;
    end
    m_last_pc = bus.pc;
  endtask

  task automatic cycle();
    bus.instr = $urandom;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.memwrite = 1'b0;
    bus.trace_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom & 32'h0000_0FFC;
    if (a == PASS_ADDR) a = a + 32'd4;
    return a;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (bus.status !== 2'b00) begin errors++; $display("FAIL reset_status got=%0h exp=0", bus.status); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    checks++; if (bus.trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.trace_valid); end
    checks++; if (bus.trace_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.trace_addr); end
    checks++; if (bus.trace_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.trace_data); end
    checks++; if (bus.trace_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", bus.trace_ovf); end
    checks++; if (bus.write_count !== 16'h0) begin errors++; $display("FAIL reset_wc got=%0d exp=0", bus.write_count); end
    checks++; if (bus.cycle_count !== 32'h0) begin errors++; $display("FAIL reset_cc got=%0d exp=0", bus.cycle_count); end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_pass();
    do_reset();
    bus.pc = 32'h100;
    for (int i = 0; i < 50; i++) begin
      bus.pc = bus.pc + 32'd4;
      bus.memwrite = 1'($urandom_range(1));
      bus.dataadr = rand_addr();
      bus.writedata = $urandom;
      bus.trace_ready = 1'($urandom_range(1));
      cycle();
      checks++; if (bus.status !== 2'(m_status)) begin errors++; $display("FAIL pass_run_status cyc=%0d got=%0h exp=%0h", i, bus.status, m_status); end
    end
    bus.pc = bus.pc + 32'd4;
    bus.memwrite = 1'b1;
    bus.dataadr = PASS_ADDR;
    bus.writedata = PASS_DATA;
    cycle();
    checks++; if (bus.status !== 2'b01) begin errors++; $display("FAIL pass_status got=%0h exp=1", bus.status); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL pass_done got=%0b exp=1", bus.done); end
    checks++; if (bus.cycle_count !== 32'd51) begin errors++; $display("FAIL pass_cc got=%0d exp=51", bus.cycle_count); end
    checks++; if (bus.write_count !== 16'(m_wc)) begin errors++; $display("FAIL pass_wc got=%0d exp=%0d", bus.write_count, m_wc); end
    // Terminal: counters frozen, no pushes, FIFO drains to empty.
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.pc = bus.pc + 32'd4;
      bus.memwrite = 1'($urandom_range(1));
      bus.dataadr = rand_addr();
      cycle();
    end
    checks++; if (bus.cycle_count !== 32'd51) begin errors++; $display("FAIL pass_cc_frozen got=%0d exp=51", bus.cycle_count); end
    checks++; if (bus.write_count !== 16'(m_wc)) begin errors++; $display("FAIL pass_wc_frozen got=%0d exp=%0d", bus.write_count, m_wc); end
    checks++; if (bus.status !== 2'b01) begin errors++; $display("FAIL pass_held got=%0h exp=1", bus.status); end
    checks++; if (bus.trace_valid !== 1'b0) begin errors++; $display("FAIL pass_drained got=%0b exp=0", bus.trace_valid); end
    $display("test_pass done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_fail();
    do_reset();
    bus.pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      bus.pc = bus.pc + 32'd4;
      cycle();
    end
    bus.memwrite = 1'b1;
    bus.dataadr = PASS_ADDR;
    bus.writedata = 32'd5;
    cycle();
    bus.memwrite = 1'b0;
    checks++; if (bus.status !== 2'b10) begin errors++; $display("FAIL fail_status got=%0h exp=2", bus.status); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL fail_done got=%0b exp=1", bus.done); end
    checks++; if (bus.trace_valid !== 1'b1) begin errors++; $display("FAIL fail_valid got=%0b exp=1", bus.trace_valid); end
    checks++; if (bus.trace_addr !== 32'h54) begin errors++; $display("FAIL fail_head_addr got=%h exp=54", bus.trace_addr); end
    checks++; if (bus.trace_data !== 32'd5) begin errors++; $display("FAIL fail_head_data got=%h exp=5", bus.trace_data); end
    $display("test_fail done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_hang();
    do_reset();
    bus.pc = 32'h1C;
    bus.memwrite = 1'b0;
    for (int i = 0; i < 64; i++) cycle();
    checks++; if (bus.status !== 2'b00) begin errors++; $display("FAIL hang_early got=%0h exp=0", bus.status); end
    cycle();
    checks++; if (bus.status !== 2'b11) begin errors++; $display("FAIL hang_status got=%0h exp=3", bus.status); end
    checks++; if (bus.status !== 2'(m_status)) begin errors++; $display("FAIL hang_model got=%0h exp=%0h", bus.status, m_status); end
    checks++; if (bus.write_count !== 16'h0) begin errors++; $display("FAIL hang_wc got=%0d exp=0", bus.write_count); end
    $display("test_hang done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_overflow();
    logic [63:0] exp_e[11];
    logic [63:0] order[8];
    do_reset();
    bus.pc = 32'h300;
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 11; i++) exp_e[i] = {rand_addr(), 32'($urandom)};
    for (int i = 0; i < 10; i++) begin
      bus.pc = bus.pc + 32'd4;
      bus.memwrite = 1'b1;
      {bus.dataadr, bus.writedata} = exp_e[i];
      cycle();
    end
    bus.memwrite = 1'b0;
    checks++; if (bus.write_count !== 16'd10) begin errors++; $display("FAIL ovf_wc got=%0d exp=10", bus.write_count); end
    checks++; if (bus.trace_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", bus.trace_ovf); end
    checks++; if ({bus.trace_addr, bus.trace_data} !== exp_e[0]) begin errors++; $display("FAIL ovf_head got=%h exp=%h", {bus.trace_addr, bus.trace_data}, exp_e[0]); end
    // Pop and push in the same cycle while full.
    bus.pc = bus.pc + 32'd4;
    bus.memwrite = 1'b1;
    {bus.dataadr, bus.writedata} = exp_e[10];
    bus.trace_ready = 1'b1;
    cycle();
    bus.memwrite = 1'b0;
    checks++; if (bus.write_count !== 16'd11) begin errors++; $display("FAIL ovf_wc2 got=%0d exp=11", bus.write_count); end
    for (int k = 0; k < 7; k++) order[k] = exp_e[k + 1];
    order[7] = exp_e[10];
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.trace_valid !== 1'b1 || {bus.trace_addr, bus.trace_data} !== order[k]) begin
        errors++;
        $display("FAIL ovf_drain k=%0d got=%0b/%h exp=1/%h", k, bus.trace_valid, {bus.trace_addr, bus.trace_data}, order[k]);
      end
      bus.pc = bus.pc + 32'd4;
      cycle();
    end
    checks++; if (bus.trace_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%0b exp=0", bus.trace_valid); end
    checks++; if (bus.trace_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", bus.trace_ovf); end
    $display("test_overflow done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.pc = 32'h400;
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.pc = bus.pc + 32'd4;
      bus.memwrite = 1'b1;
      bus.dataadr = rand_addr();
      bus.writedata = $urandom;
      cycle();
    end
    bus.dataadr = PASS_ADDR;
    bus.writedata = PASS_DATA;
    cycle();
    checks++; if (bus.status !== 2'b01) begin errors++; $display("FAIL mid_pass got=%0h exp=1", bus.status); end
    do_reset();
    checks++; if (bus.status !== 2'b00 || bus.done !== 1'b0) begin errors++; $display("FAIL mid_status got=%0h/%0b exp=0/0", bus.status, bus.done); end
    checks++; if (bus.trace_valid !== 1'b0 || bus.trace_addr !== 32'h0) begin errors++; $display("FAIL mid_fifo got=%0b/%h exp=0/0", bus.trace_valid, bus.trace_addr); end
    checks++; if (bus.write_count !== 16'h0 || bus.cycle_count !== 32'h0) begin errors++; $display("FAIL mid_counts got=%0d/%0d exp=0/0", bus.write_count, bus.cycle_count); end
    checks++; if (bus.trace_ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf got=%0b exp=0", bus.trace_ovf); end
    bus.memwrite = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.pc = bus.pc + 32'd4;
      cycle();
    end
    bus.memwrite = 1'b1;
    bus.dataadr = PASS_ADDR;
    bus.writedata = PASS_DATA;
    cycle();
    bus.memwrite = 1'b0;
    checks++; if (bus.status !== 2'b01) begin errors++; $display("FAIL mid_rerun got=%0h exp=1", bus.status); end
    checks++; if (bus.cycle_count !== 32'd6 || bus.write_count !== 16'd1) begin errors++; $display("FAIL mid_rerun_counts got=%0d/%0d exp=6/1", bus.cycle_count, bus.write_count); end
    $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_priority();
    do_reset();
    bus.pc = 32'h1C;
    bus.memwrite = 1'b0;
    for (int i = 0; i < 64; i++) cycle();
    bus.memwrite = 1'b1;
    bus.dataadr = PASS_ADDR;
    bus.writedata = PASS_DATA;
    cycle();
    bus.memwrite = 1'b0;
    checks++; if (bus.status !== 2'b01) begin errors++; $display("FAIL prio_status got=%0h exp=1", bus.status); end
    $display("test_priority done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random_budget();
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    do_reset();
    bus.pc = 32'h800;
    for (int i = 0; i < MAX_CYCLES + 50 && m_status == 0; i++) begin
      if ($urandom_range(3) != 0) bus.pc = bus.pc + 32'd4;
      bus.memwrite = 1'($urandom_range(1));
      bus.dataadr = rand_addr();
      bus.writedata = $urandom;
      bus.trace_ready = ($urandom_range(3) == 0);
      cycle();
      exp_addr = (m_q.size() > 0) ? m_q[0][63:32] : 32'h0;
      exp_data = (m_q.size() > 0) ? m_q[0][31:0] : 32'h0;
      checks++;
      if (bus.status !== 2'(m_status) || bus.done !== (m_status != 0) ||
          bus.write_count !== 16'(m_wc) || bus.cycle_count !== 32'(m_cc) ||
          bus.trace_valid !== (m_q.size() > 0) || bus.trace_ovf !== m_ovf ||
          bus.trace_addr !== exp_addr || bus.trace_data !== exp_data) begin
        errors++;
        $display("FAIL rand cyc=%0d got st=%0h wc=%0d cc=%0d v=%0b ovf=%0b head=%h_%h exp st=%0h wc=%0d cc=%0d v=%0b ovf=%0b head=%h_%h",
                 i, bus.status, bus.write_count, bus.cycle_count, bus.trace_valid, bus.trace_ovf,
                 bus.trace_addr, bus.trace_data, m_status, m_wc, m_cc, m_q.size() > 0, m_ovf, exp_addr, exp_data);
      end
    end
    checks++; if (bus.status !== 2'b11) begin errors++; $display("FAIL budget_status got=%0h exp=3", bus.status); end
    checks++; if (bus.cycle_count !== 32'(MAX_CYCLES)) begin errors++; $display("FAIL budget_cc got=%0d exp=%0d", bus.cycle_count, MAX_CYCLES); end
    $display("test_random_budget done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    bus.pc = 32'h0;
    bus.instr = 32'h0;
    bus.memwrite = 1'b0;
    bus.dataadr = 32'h0;
    bus.writedata = 32'h0;
    bus.trace_ready = 1'b0;
    test_reset();
    test_pass();
    test_fail();
    test_hang();
    test_overflow();
    test_reset_mid();
    test_priority();
    test_random_budget();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
